// File: rtl/array_inst_sequencer.sv
// Per-tile instruction sequencer for the systolic-array core.
// Emits a registered 34-bit inst word: weight fetch/load, act fetch, execute, drain.
module array_inst_sequencer #(
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_x_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic [cnt_bw-1:0]  cfg_n_act,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WF,
    S_WL,
    S_XF,
    S_EX,
    S_DR,
    S_FIN
  } state_t;

  localparam logic [cnt_bw-1:0] COL_C = cnt_bw'(col);
  localparam logic [33:0] IDLE_W =
    (34'd1 << 32) | (34'd1 << 31) |
    (34'd1 << 19) | (34'd1 << 18);

  state_t             state;
  state_t             state_n;
  logic [cnt_bw-1:0]  cnt;
  logic [cnt_bw-1:0]  cnt_n;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic [addr_bw-1:0] p_base;
  logic [cnt_bw-1:0]  n_act;
  logic [33:0]        inst_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      w_base <= '0;
      x_base <= '0;
      p_base <= '0;
      n_act  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_IDLE && start) begin
        w_base <= cfg_w_base;
        x_base <= cfg_x_base;
        p_base <= cfg_p_base;
        n_act  <= cfg_n_act;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WF;
          cnt_n   = '0;
        end
      end
      S_WF: begin
        if (cnt == COL_C) begin
          state_n = S_WL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WL: begin
        if (cnt == COL_C - 1'b1) begin
          state_n = (n_act == '0) ? S_FIN : S_XF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_XF: begin
        if (cnt == n_act) begin
          state_n = S_EX;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_EX: begin
        if (cnt == n_act - 1'b1) begin
          state_n = S_DR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DR: begin
        if (ofifo_valid) begin
          if (cnt == n_act - 1'b1) begin
            state_n = S_FIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // l0_wr trails each xmem read by one cycle: SRAM data lags the request.
  always_comb begin
    logic               cen_p;
    logic               wen_p;
    logic [addr_bw-1:0] a_p;
    logic               cen_x;
    logic               wen_x;
    logic [addr_bw-1:0] a_x;
    logic               of_rd;
    logic               l0_rd;
    logic               l0_wr;
    logic               exe;
    logic               ld;
    cen_p = 1'b1;
    wen_p = 1'b1;
    a_p   = '0;
    cen_x = 1'b1;
    wen_x = 1'b1;
    a_x   = '0;
    of_rd = 1'b0;
    l0_rd = 1'b0;
    l0_wr = 1'b0;
    exe   = 1'b0;
    ld    = 1'b0;
    unique case (state)
      S_WF: begin
        if (cnt < COL_C) begin
          cen_x = 1'b0;
          a_x   = w_base + addr_bw'(cnt);
        end
        l0_wr = (cnt != '0);
      end
      S_WL: begin
        l0_rd = 1'b1;
        ld    = 1'b1;
      end
      S_XF: begin
        if (cnt < n_act) begin
          cen_x = 1'b0;
          a_x   = x_base + addr_bw'(cnt);
        end
        l0_wr = (cnt != '0);
      end
      S_EX: begin
        l0_rd = 1'b1;
        exe   = 1'b1;
      end
      S_DR: begin
        if (ofifo_valid) begin
          of_rd = 1'b1;
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = p_base + addr_bw'(cnt);
        end
      end
      default: begin
      end
    endcase
    inst_n = {1'b0, cen_p, wen_p, a_p,
              cen_x, wen_x, a_x,
              of_rd, 1'b0, 1'b0,
              l0_rd, l0_wr, exe, ld};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst <= IDLE_W;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      inst <= inst_n;
      busy <= (state_n != S_IDLE);
      done <= (state == S_FIN);
    end
  end

endmodule

// File: tb/tb_array_inst_sequencer.sv
// Bench for array_inst_sequencer: table vectors, random tiles, reset abort.
// Expected inst streams are built phase by phase from the tile rules.
module tb_array_inst_sequencer;

  localparam int COL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] cfg_w_base;
  logic [10:0] cfg_x_base;
  logic [10:0] cfg_p_base;
  logic [10:0] cfg_n_act;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  array_inst_sequencer #(.col(COL), .addr_bw(11), .cnt_bw(11)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_w_base(cfg_w_base),
    .cfg_x_base(cfg_x_base),
    .cfg_p_base(cfg_p_base),
    .cfg_n_act(cfg_n_act),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int x;
    int p;
    int n;
    int mode;
    int restart;
    int exp_total;
  } vec_t;

  vec_t        tbl[6];
  logic [33:0] q[$];
  bit          vpat[4096];

  function automatic logic [33:0] mk(
    bit cp, bit wp, int ap, bit cx, bit wx, int ax,
    bit ofr, bit lr, bit lw, bit ex, bit ld);
    logic [33:0] r;
    r = '0;
    r[32] = cp;
    r[31] = wp;
    r[30:20] = 11'(ap % 2048);
    r[19] = cx;
    r[18] = wx;
    r[17:7] = 11'(ax % 2048);
    r[6] = ofr;
    r[3] = lr;
    r[2] = lw;
    r[1] = ex;
    r[0] = ld;
    return r;
  endfunction

  function automatic logic [33:0] idle_w();
    return mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check(string name, logic [33:0] act, logic [33:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic build_model(int w, int x, int p, int n);
    int c;
    int wr;
    q.delete();
    for (int i = 0; i <= COL; i++)
      q.push_back(mk(1, 1, 0, i >= COL, 1, (i < COL) ? w + i : 0,
                     0, 0, i >= 1, 0, 0));
    for (int i = 0; i < COL; i++)
      q.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1));
    if (n > 0) begin
      for (int i = 0; i <= n; i++)
        q.push_back(mk(1, 1, 0, i >= n, 1, (i < n) ? x + i : 0,
                       0, 0, i >= 1, 0, 0));
      for (int i = 0; i < n; i++)
        q.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0));
      c = q.size();
      wr = 0;
      while (wr < n) begin
        if (vpat[c]) begin
          q.push_back(mk(0, 0, p + wr, 1, 1, 0, 1, 0, 0, 0, 0));
          wr++;
        end else begin
          q.push_back(idle_w());
        end
        c++;
      end
    end
    q.push_back(idle_w());
  endtask

  task automatic run_tile(vec_t v);
    int d0;
    int tot;
    int rs;
    bit pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    d0 = 2 * COL + 2 + 2 * v.n;
    for (int i = 0; i < 4096; i++) begin
      if (v.mode == 0) vpat[i] = 1;
      else if (v.mode == 1) vpat[i] = 1'($urandom_range(0, 1));
      else vpat[i] = (i >= d0 && i < d0 + 7) ? pat[i - d0] : 1'b1;
    end
    build_model(v.w, v.x, v.p, v.n);
    tot = (v.exp_total != 0) ? v.exp_total : q.size();
    rs = 2 * COL + 3 + v.n;
    cfg_w_base = 11'(v.w);
    cfg_x_base = 11'(v.x);
    cfg_p_base = 11'(v.p);
    cfg_n_act  = 11'(v.n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ofifo_valid = vpat[0];
    check("busy_after_start", 34'(busy), 34'd1);
    for (int s = 1; s <= tot; s++) begin
      @(posedge clk);
      #1;
      check($sformatf("inst[%0d]", s), inst,
            (s - 1 < q.size()) ? q[s - 1] : idle_w());
      check($sformatf("done[%0d]", s), 34'(done), 34'(s == tot));
      check($sformatf("busy[%0d]", s), 34'(busy), 34'(s < tot));
      ofifo_valid = vpat[s];
      start = 1'b0;
      if (v.restart != 0 && v.n > 0 && s == rs) begin
        start = 1'b1;
        cfg_w_base = 11'd1000;
        cfg_x_base = 11'd1500;
        cfg_p_base = 11'd700;
        cfg_n_act  = 11'd3;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_done", 34'(done), 34'd0);
      check("post_busy", 34'(busy), 34'd0);
      check("post_inst", inst, idle_w());
    end
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{w: 0, x: 8, p: 0, n: 4, mode: 0, restart: 0, exp_total: 31};
    tbl[1] = '{w: 0, x: 8, p: 0, n: 4, mode: 2, restart: 0, exp_total: 34};
    tbl[2] = '{w: 0, x: 8, p: 0, n: 0, mode: 0, restart: 0, exp_total: 18};
    tbl[3] = '{w: 0, x: 2046, p: 0, n: 4, mode: 0, restart: 0, exp_total: 31};
    tbl[4] = '{w: 5, x: 8, p: 100, n: 4, mode: 0, restart: 1, exp_total: 31};
    tbl[5] = '{w: 2044, x: 2040, p: 2046, n: 6, mode: 1, restart: 0, exp_total: 0};

    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    cfg_w_base = '0;
    cfg_x_base = '0;
    cfg_p_base = '0;
    cfg_n_act = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inst", inst, idle_w());
    check("reset_busy", 34'(busy), 34'd0);
    check("reset_done", 34'(done), 34'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_start_low", inst, idle_w());

    for (int t = 0; t < 6; t++) run_tile(tbl[t]);

    // abort: reset lands during EXEC cycle 5 of a 16-vector tile
    cfg_w_base = 11'd0;
    cfg_x_base = 11'd8;
    cfg_p_base = 11'd0;
    cfg_n_act = 11'd16;
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int s = 1; s <= 39; s++) begin
      @(posedge clk);
      #1;
    end
    check("exec_before_reset", 34'(inst[1]), 34'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_inst", inst, idle_w());
    check("abort_busy", 34'(busy), 34'd0);
    check("abort_done", 34'(done), 34'd0);
    @(posedge clk);
    #1;
    check("abort_stays_idle", inst, idle_w());
    check("abort_stays_nbusy", 34'(busy), 34'd0);
    run_tile(tbl[0]);

    for (int r = 0; r < 6; r++) begin
      rv.w = $urandom_range(0, 2047);
      rv.x = $urandom_range(0, 2047);
      rv.p = $urandom_range(0, 2047);
      rv.n = $urandom_range(0, 20);
      rv.mode = 1;
      rv.restart = $urandom_range(0, 1);
      rv.exp_total = 0;
      run_tile(rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
